// File: rtl/seq_bin2bcd_pkg.sv
// Shared types and constants for the sequential double-dabble BCD converter.
package seq_bin2bcd_pkg;

    // Converter control states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Width of one packed BCD digit.
    localparam int unsigned DIGIT_W = 4;

    // A digit at or above this value gets corrected before the next doubling.
    localparam int unsigned ADJ_THRESH = 5;

    // Correction added so that doubling carries into the next decimal digit.
    localparam int unsigned ADJ_ADD = 3;

    // Largest legal BCD digit, used to saturate on overflow.
    localparam int unsigned DIGIT_MAX = 9;

endpackage

// File: rtl/seq_bin2bcd_digit_adjust.sv
// Shift-add-3 correction for one BCD digit: add 3 when the digit is 5 or more.
module bcd_digit_adjust
    import seq_bin2bcd_pkg::*;
(
    input  logic [DIGIT_W-1:0] digit,
    output logic [DIGIT_W-1:0] adjusted_c
);

    // Correct the digit so the following left shift produces a decimal carry.
    always_comb begin
        adjusted_c = digit;
        if (digit >= DIGIT_W'(ADJ_THRESH)) begin
            adjusted_c = digit + DIGIT_W'(ADJ_ADD);
        end
    end

endmodule

// File: rtl/seq_bin2bcd.sv
// Sequential signed binary to packed BCD converter (double dabble) with
// start/done handshake; saturates to all nines when the magnitude does not fit.
module seq_bin2bcd
    import seq_bin2bcd_pkg::*;
#(
    parameter int unsigned Word_Length = 6,
    parameter int unsigned Digits      = 4
)
(
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         Start,
    input  logic [2*Word_Length-1:0]     Data_Input,
    output logic                         Busy,
    output logic                         Done,
    output logic                         Valid,
    output logic                         Sign_Output,
    output logic [DIGIT_W*Digits-1:0]    BCD_Output,
    output logic                         Overflow
);

    localparam int unsigned PW = 2 * Word_Length;
    localparam int unsigned BW = DIGIT_W * Digits;
    localparam int unsigned CW = $clog2(PW + 1);
    localparam logic [BW-1:0] NINES = {Digits{DIGIT_W'(DIGIT_MAX)}};

    state_t          state_q, state_d;
    logic [PW-1:0]   mag_q, mag_d;
    logic            sign_q, sign_d;
    logic [BW-1:0]   scratch_q, scratch_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            sticky_q, sticky_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            valid_q, valid_d;
    logic            sign_out_q, sign_out_d;
    logic [BW-1:0]   bcd_q, bcd_d;
    logic            ovf_q, ovf_d;

    logic [BW-1:0]   adj_c;
    logic [PW-1:0]   abs_c;
    logic            shout_c;

    // Per-digit add-3 correction applied to the scratch register every shift.
    for (genvar g = 0; g < int'(Digits); g++) begin : g_adj
        bcd_digit_adjust u_adj (
            .digit      (scratch_q[g*DIGIT_W +: DIGIT_W]),
            .adjusted_c (adj_c[g*DIGIT_W +: DIGIT_W])
        );
    end

    // Magnitude of the two's-complement input; the most negative value maps to 2^(PW-1).
    always_comb begin
        abs_c = Data_Input;
        if (Data_Input[PW-1]) begin
            abs_c = (~Data_Input) + PW'(1);
        end
    end

    // Next-state and datapath update for the IDLE/SHIFT/DONE sequence.
    always_comb begin
        state_d    = state_q;
        mag_d      = mag_q;
        sign_d     = sign_q;
        scratch_d  = scratch_q;
        cnt_d      = cnt_q;
        sticky_d   = sticky_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        valid_d    = valid_q;
        sign_out_d = sign_out_q;
        bcd_d      = bcd_q;
        ovf_d      = ovf_q;
        shout_c    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (Start) begin
                    state_d   = SHIFT;
                    mag_d     = abs_c;
                    sign_d    = Data_Input[PW-1];
                    scratch_d = '0;
                    cnt_d     = '0;
                    sticky_d  = 1'b0;
                    valid_d   = 1'b0;
                    busy_d    = 1'b1;
                end
            end
            SHIFT: begin
                {shout_c, scratch_d, mag_d} = {adj_c, mag_q, 1'b0};
                if (shout_c) begin
                    sticky_d = 1'b1;
                end
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(PW - 1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d    = IDLE;
                busy_d     = 1'b0;
                sign_out_d = sign_q;
                ovf_d      = sticky_q;
                bcd_d      = sticky_q ? NINES : scratch_q;
                done_d     = 1'b1;
                valid_d    = 1'b1;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State, scratch and published-result registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            mag_q      <= '0;
            sign_q     <= 1'b0;
            scratch_q  <= '0;
            cnt_q      <= '0;
            sticky_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            valid_q    <= 1'b0;
            sign_out_q <= 1'b0;
            bcd_q      <= '0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            mag_q      <= mag_d;
            sign_q     <= sign_d;
            scratch_q  <= scratch_d;
            cnt_q      <= cnt_d;
            sticky_q   <= sticky_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            valid_q    <= valid_d;
            sign_out_q <= sign_out_d;
            bcd_q      <= bcd_d;
            ovf_q      <= ovf_d;
        end
    end

    assign Busy        = busy_q;
    assign Done        = done_q;
    assign Valid       = valid_q;
    assign Sign_Output = sign_out_q;
    assign BCD_Output  = bcd_q;
    assign Overflow    = ovf_q;

endmodule

// File: tb/tb_seq_bin2bcd.sv
// Directed bench for seq_bin2bcd: default 6-bit build plus an 8-bit build.
module tb_seq_bin2bcd;

    logic        clk = 1'b0;
    logic        reset;

    logic        start;
    logic [11:0] data;
    logic        busy, done, valid, sign, ovf;
    logic [15:0] bcd;

    logic        start8;
    logic [15:0] data8;
    logic        busy8, done8, valid8, sign8, ovf8;
    logic [15:0] bcd8;

    int checks   = 0;
    int failures = 0;

    seq_bin2bcd #(.Word_Length(6), .Digits(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .Start       (start),
        .Data_Input  (data),
        .Busy        (busy),
        .Done        (done),
        .Valid       (valid),
        .Sign_Output (sign),
        .BCD_Output  (bcd),
        .Overflow    (ovf)
    );

    seq_bin2bcd #(.Word_Length(8), .Digits(4)) dut8 (
        .clk         (clk),
        .reset       (reset),
        .Start       (start8),
        .Data_Input  (data8),
        .Busy        (busy8),
        .Done        (done8),
        .Valid       (valid8),
        .Sign_Output (sign8),
        .BCD_Output  (bcd8),
        .Overflow    (ovf8)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One conversion on the 6-bit build; lat counts edges from E0 to Done visible.
    task automatic conv6(input logic [11:0] d, output int lat, output int bc, output logic v0);
        start = 1'b1;
        data  = d;
        tick();
        start = 1'b0;
        data  = 12'($urandom);
        v0    = valid;
        bc    = busy ? 1 : 0;
        lat   = 0;
        while (lat < 40) begin
            tick();
            lat++;
            if (busy) bc++;
            if (done) break;
        end
    endtask

    task automatic conv8(input logic [15:0] d, output int lat);
        start8 = 1'b1;
        data8  = d;
        tick();
        start8 = 1'b0;
        data8  = 16'($urandom);
        lat    = 0;
        while (lat < 40) begin
            tick();
            lat++;
            if (done8) break;
        end
    endtask

    initial begin
        int   lat, bc, dcnt, first, second;
        logic v0;

        reset  = 1'b1;
        start  = 1'b0;
        data   = '0;
        start8 = 1'b0;
        data8  = '0;
        tick();
        tick();
        check("rst_busy",  64'(busy),  64'(0));
        check("rst_done",  64'(done),  64'(0));
        check("rst_valid", 64'(valid), 64'(0));
        check("rst_sign",  64'(sign),  64'(0));
        check("rst_bcd",   64'(bcd),   64'(0));
        check("rst_ovf",   64'(ovf),   64'(0));
        reset = 1'b0;
        tick();

        // 1024 positive
        conv6(12'd1024, lat, bc, v0);
        check("p1024_lat",   64'(lat),   64'(13));
        check("p1024_bcd",   64'(bcd),   64'h1024);
        check("p1024_sign",  64'(sign),  64'(0));
        check("p1024_ovf",   64'(ovf),   64'(0));
        check("p1024_valid", 64'(valid), 64'(1));
        tick();
        check("p1024_done_pulse", 64'(done),  64'(0));
        check("p1024_hold",       64'(bcd),   64'h1024);
        check("p1024_valid_hold", 64'(valid), 64'(1));

        // -30: Valid drops at E0, Busy covers E0..E13 (13 sampled cycles)
        conv6(-12'sd30, lat, bc, v0);
        check("n30_valid_e0", 64'(v0),   64'(0));
        check("n30_busy_cyc", 64'(bc),   64'(13));
        check("n30_lat",      64'(lat),  64'(13));
        check("n30_bcd",      64'(bcd),  64'h0030);
        check("n30_sign",     64'(sign), 64'(1));
        check("n30_busy_end", 64'(busy), 64'(0));

        // most negative input
        conv6(12'h800, lat, bc, v0);
        check("n2048_bcd",  64'(bcd),  64'h2048);
        check("n2048_sign", 64'(sign), 64'(1));
        check("n2048_ovf",  64'(ovf),  64'(0));

        // most positive input
        conv6(12'h7FF, lat, bc, v0);
        check("p2047_bcd",  64'(bcd),  64'h2047);
        check("p2047_sign", 64'(sign), 64'(0));

        // 8-bit build: overflow and the boundary either side of it
        conv8(16'd12345, lat);
        check("w8_12345_lat",  64'(lat),   64'(17));
        check("w8_12345_ovf",  64'(ovf8),  64'(1));
        check("w8_12345_bcd",  64'(bcd8),  64'h9999);
        check("w8_12345_sign", 64'(sign8), 64'(0));
        conv8(-16'sd9999, lat);
        check("w8_n9999_ovf",  64'(ovf8),  64'(0));
        check("w8_n9999_bcd",  64'(bcd8),  64'h9999);
        check("w8_n9999_sign", 64'(sign8), 64'(1));
        conv8(16'd10000, lat);
        check("w8_10000_ovf",  64'(ovf8),  64'(1));
        check("w8_10000_bcd",  64'(bcd8),  64'h9999);
        conv8(16'd4821, lat);
        check("w8_4821_ovf",   64'(ovf8),  64'(0));
        check("w8_4821_bcd",   64'(bcd8),  64'h4821);

        // Start while busy is ignored
        start = 1'b1;
        data  = 12'd45;
        tick();
        start = 1'b0;
        dcnt  = 0;
        for (int i = 1; i <= 20; i++) begin
            if (i == 5) begin
                start = 1'b1;
                data  = 12'd99;
            end else begin
                start = 1'b0;
            end
            tick();
            if (done) dcnt++;
        end
        start = 1'b0;
        check("busy_start_done_cnt", 64'(dcnt), 64'(1));
        check("busy_start_bcd",      64'(bcd),  64'h0045);
        conv6(12'd7, lat, bc, v0);
        check("third_start_lat", 64'(lat), 64'(13));
        check("third_start_bcd", 64'(bcd), 64'h0007);

        // Start held high: one acceptance every 14 cycles
        start = 1'b1;
        data  = 12'd5;
        tick();
        first  = -1;
        second = -1;
        for (int n = 1; n <= 40; n++) begin
            tick();
            if (done) begin
                if (first < 0) begin
                    first = n;
                end else begin
                    second = n;
                    break;
                end
            end
        end
        start = 1'b0;
        check("hold_first",    64'(first),          64'(13));
        check("hold_interval", 64'(second - first), 64'(14));
        check("hold_bcd",      64'(bcd),            64'h0005);

        // reset mid-conversion aborts without a Done pulse
        start = 1'b1;
        data  = 12'd99;
        tick();
        start = 1'b0;
        dcnt  = 0;
        for (int i = 1; i <= 5; i++) begin
            tick();
            if (done) dcnt++;
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort_busy",  64'(busy),  64'(0));
        check("abort_valid", 64'(valid), 64'(0));
        check("abort_bcd",   64'(bcd),   64'(0));
        check("abort_done",  64'(done),  64'(0));
        for (int i = 0; i < 15; i++) begin
            tick();
            if (done) dcnt++;
        end
        check("abort_no_done", 64'(dcnt), 64'(0));
        conv6(12'd0, lat, bc, v0);
        check("zero_lat",   64'(lat),   64'(13));
        check("zero_bcd",   64'(bcd),   64'(0));
        check("zero_sign",  64'(sign),  64'(0));
        check("zero_valid", 64'(valid), 64'(1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
